// File: rtl/approx_adder_sweep_checker.sv
// Exhaustive sweep driver and error checker wrapped around a combinational (or
// LAT-cycle pipelined) approximate adder netlist.
module approx_adder_sweep_checker #(
  parameter int OPW = 2,
  parameter int ET  = 5,
  parameter int LAT = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic [2*OPW-1:0]   dut_in,
  input  logic [OPW:0]       dut_out,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [OPW:0]       max_err,
  output logic [3*OPW+1:0]   err_sum,
  output logic [2*OPW:0]     viol_cnt,
  output logic [2*OPW-1:0]   first_viol_vec,
  output logic               first_viol_vld
);

  // state | meaning
  // IDLE  | waiting for the first start after reset
  // SWEEP | driving vectors 0 .. 2^(2*OPW)-1, one per cycle
  // DRAIN | holding the last vector while the delay line empties
  // DONE  | statistics final, waiting for the next start
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam int VW  = 2 * OPW;
  localparam int SW  = OPW + 1;
  localparam int ESW = 3 * OPW + 2;
  localparam int CW  = 2 * OPW + 1;
  localparam logic [VW-1:0] VEC_LAST = '1;

  logic [1:0]    state_q;
  logic [VW-1:0] vec_q;
  logic [1:0]    drain_q;
  logic          drv_vld;
  logic          smp_vld;
  logic [VW-1:0] smp_vec;
  logic [SW-1:0] exact;
  logic [SW-1:0] err;
  logic          viol;

  assign dut_in  = vec_q;
  assign drv_vld = (state_q == S_SWEEP);
  assign busy    = (state_q == S_SWEEP) || (state_q == S_DRAIN);
  assign done    = (state_q == S_DONE);
  assign pass    = done && (viol_cnt == '0);

  // Delay line pairs each driven vector with the DUT output it produces LAT cycles later.
  generate
    if (LAT == 0) begin : g_comb
      assign smp_vld = drv_vld;
      assign smp_vec = vec_q;
    end else begin : g_pipe
      logic [LAT-1:0] vld_pipe;
      logic [VW-1:0]  vec_pipe [LAT];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_pipe <= '0;
          for (int i = 0; i < LAT; i++) vec_pipe[i] <= '0;
        end else begin
          vld_pipe[0] <= drv_vld;
          vec_pipe[0] <= vec_q;
          for (int i = 1; i < LAT; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
            vec_pipe[i] <= vec_pipe[i-1];
          end
        end
      end
      assign smp_vld = vld_pipe[LAT-1];
      assign smp_vec = vec_pipe[LAT-1];
    end
  endgenerate

  assign exact = SW'(smp_vec[OPW-1:0]) + SW'(smp_vec[VW-1:OPW]);
  assign err   = (dut_out >= exact) ? (dut_out - exact) : (exact - dut_out);
  assign viol  = int'(err) > ET;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      drain_q <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_SWEEP;
            vec_q   <= '0;
          end
        end
        S_SWEEP: begin
          if (vec_q == VEC_LAST) begin
            state_q <= (LAT == 0) ? S_DONE : S_DRAIN;
            drain_q <= 2'(LAT);
          end else begin
            vec_q <= vec_q + 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_q <= 2'd1) state_q <= S_DONE;
          else                 drain_q <= drain_q - 2'd1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // A start is only honoured from IDLE/DONE, so statistics never clear mid-sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_err        <= '0;
      err_sum        <= '0;
      viol_cnt       <= '0;
      first_viol_vec <= '0;
      first_viol_vld <= 1'b0;
    end else if (start && (state_q == S_IDLE || state_q == S_DONE)) begin
      max_err        <= '0;
      err_sum        <= '0;
      viol_cnt       <= '0;
      first_viol_vec <= '0;
      first_viol_vld <= 1'b0;
    end else if (smp_vld) begin
      err_sum <= err_sum + ESW'(err);
      if (err > max_err) max_err <= err;
      if (viol) begin
        viol_cnt <= viol_cnt + CW'(1);
        if (!first_viol_vld) begin
          first_viol_vec <= smp_vec;
          first_viol_vld <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_approx_adder_sweep_checker.sv
// Directed bench: LAT=0 instance with a selectable adder model, and a LAT=2
// instance fed by an exact adder registered twice.
module tb_approx_adder_sweep_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [3:0] dut_in0, dut_in1, fvv0, fvv1;
  logic [2:0] dut_out0, dut_out1, merr0, merr1, p1, p2;
  logic [7:0] esum0, esum1;
  logic [4:0] vcnt0, vcnt1;
  logic       busy0, busy1, done0, done1, pass0, pass1, fvl0, fvl1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  approx_adder_sweep_checker #(.OPW(2), .ET(5), .LAT(0)) u_lat0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .dut_in(dut_in0), .dut_out(dut_out0),
    .busy(busy0), .done(done0), .pass(pass0), .max_err(merr0), .err_sum(esum0),
    .viol_cnt(vcnt0), .first_viol_vec(fvv0), .first_viol_vld(fvl0));

  approx_adder_sweep_checker #(.OPW(2), .ET(5), .LAT(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .pass(pass1), .max_err(merr1), .err_sum(esum1),
    .viol_cnt(vcnt1), .first_viol_vec(fvv1), .first_viol_vld(fvl1));

  // mode 0: exact adder, 1: output stuck at 7, 2: output stuck at 0
  always_comb begin
    dut_out0 = {1'b0, dut_in0[1:0]} + {1'b0, dut_in0[3:2]};
    if (mode == 2'd1) dut_out0 = 3'd7;
    if (mode == 2'd2) dut_out0 = 3'd0;
  end

  always_ff @(posedge clk) begin
    p1 <= {1'b0, dut_in1[1:0]} + {1'b0, dut_in1[3:2]};
    p2 <= p1;
  end
  assign dut_out1 = p2;

  // Pulses start in cycle 0 and reports the cycle in which done is first seen high.
  task automatic do_sweep(input int inst, input int pulse_at, output int done_cyc,
                          output int busy_cyc, output logic done_at1, output logic [7:0] sum_at1);
    logic b, d;
    done_cyc = -1; busy_cyc = 0; done_at1 = 1'b1; sum_at1 = 8'hff;
    @(negedge clk);
    if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      b = (inst == 0) ? busy0 : busy1;
      d = (inst == 0) ? done0 : done1;
      if (k == 1) begin
        done_at1 = d;
        sum_at1  = (inst == 0) ? esum0 : esum1;
      end
      if (d) begin
        done_cyc = k;
        break;
      end
      if (b) busy_cyc++;
      if (inst == 0) start0 = (k == pulse_at);
      @(negedge clk);
    end
    start0 = 1'b0;
    if (done_cyc < 0) begin
      n_vec++; n_err++;
      $display("FAIL sweep_timeout inst=%0d: done never rose within 40 cycles", inst);
    end
  endtask

  task automatic test_reset();
    n_vec++; if ({busy0, done0, pass0} !== 3'b000) begin n_err++; $display("FAIL reset_flags: got %b want 000", {busy0, done0, pass0}); end
    n_vec++; if ({merr0, esum0, vcnt0} !== 16'h0) begin n_err++; $display("FAIL reset_stats: got %h want 0", {merr0, esum0, vcnt0}); end
    n_vec++; if ({fvv0, fvl0, dut_in0} !== 9'h0) begin n_err++; $display("FAIL reset_viol_dutin: got %h want 0", {fvv0, fvl0, dut_in0}); end
    n_vec++; if ({busy1, done1, esum1, dut_in1} !== 14'h0) begin n_err++; $display("FAIL reset_lat2: got %h want 0", {busy1, done1, esum1, dut_in1}); end
  endtask

  task automatic test_exact();
    int dc, bc; logic d1; logic [7:0] s1;
    mode = 2'd0;
    do_sweep(0, 0, dc, bc, d1, s1);
    n_vec++; if (dc !== 17) begin n_err++; $display("FAIL exact_done_cycle: got %0d want 17", dc); end
    n_vec++; if (bc !== 16) begin n_err++; $display("FAIL exact_busy_cycles: got %0d want 16", bc); end
    n_vec++; if ({merr0, esum0, vcnt0} !== 16'h0) begin n_err++; $display("FAIL exact_stats: got max=%0d sum=%0d viol=%0d want 0/0/0", merr0, esum0, vcnt0); end
    n_vec++; if ({pass0, fvl0, busy0} !== 3'b100) begin n_err++; $display("FAIL exact_pass: got pass/fvld/busy=%b want 100", {pass0, fvl0, busy0}); end
  endtask

  task automatic test_stuck_high(input int pulse_at);
    int dc, bc; logic d1; logic [7:0] s1;
    mode = 2'd1;
    do_sweep(0, pulse_at, dc, bc, d1, s1);
    n_vec++; if (dc !== 17) begin n_err++; $display("FAIL stuck7_done_cycle(pulse=%0d): got %0d want 17", pulse_at, dc); end
    n_vec++; if (merr0 !== 3'd7) begin n_err++; $display("FAIL stuck7_max_err: got %0d want 7", merr0); end
    n_vec++; if (esum0 !== 8'd64) begin n_err++; $display("FAIL stuck7_err_sum: got %0d want 64", esum0); end
    n_vec++; if (vcnt0 !== 5'd3) begin n_err++; $display("FAIL stuck7_viol_cnt: got %0d want 3", vcnt0); end
    n_vec++; if ({fvl0, fvv0, pass0} !== 6'b1_0000_0) begin n_err++; $display("FAIL stuck7_first_viol: got vld=%b vec=%b pass=%b want 1 0000 0", fvl0, fvv0, pass0); end
  endtask

  task automatic test_stuck_low();
    int dc, bc; logic d1; logic [7:0] s1;
    mode = 2'd2;
    do_sweep(0, 0, dc, bc, d1, s1);
    n_vec++; if (merr0 !== 3'd6) begin n_err++; $display("FAIL stuck0_max_err: got %0d want 6", merr0); end
    n_vec++; if (esum0 !== 8'd48) begin n_err++; $display("FAIL stuck0_err_sum: got %0d want 48", esum0); end
    n_vec++; if (vcnt0 !== 5'd1) begin n_err++; $display("FAIL stuck0_viol_cnt: got %0d want 1", vcnt0); end
    n_vec++; if ({fvl0, fvv0, pass0} !== 6'b1_1111_0) begin n_err++; $display("FAIL stuck0_first_viol: got vld=%b vec=%b pass=%b want 1 1111 0", fvl0, fvv0, pass0); end
  endtask

  task automatic test_latency();
    int dc, bc; logic d1; logic [7:0] s1;
    do_sweep(1, 0, dc, bc, d1, s1);
    n_vec++; if (dc !== 19) begin n_err++; $display("FAIL lat2_done_cycle: got %0d want 19", dc); end
    n_vec++; if (bc !== 18) begin n_err++; $display("FAIL lat2_busy_cycles: got %0d want 18", bc); end
    n_vec++; if (dut_in1 !== 4'hf) begin n_err++; $display("FAIL lat2_last_vec: got %h want f", dut_in1); end
    n_vec++; if ({merr1, esum1, vcnt1, fvl1} !== 17'h0) begin n_err++; $display("FAIL lat2_stats: got max=%0d sum=%0d viol=%0d fvld=%b want 0", merr1, esum1, vcnt1, fvl1); end
    n_vec++; if (pass1 !== 1'b1) begin n_err++; $display("FAIL lat2_pass: got %b want 1", pass1); end
  endtask

  task automatic test_reset_mid_sweep();
    int dc, bc; logic d1; logic [7:0] s1;
    mode = 2'd2;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    repeat (7) @(negedge clk);
    n_vec++; if ({busy0, dut_in0} !== 5'b1_0111) begin n_err++; $display("FAIL midreset_pre: got busy/dut_in=%b want 1 0111", {busy0, dut_in0}); end
    rst_n = 1'b0;
    #1;
    n_vec++; if ({busy0, done0, pass0, dut_in0} !== 7'h0) begin n_err++; $display("FAIL midreset_ctrl: got %b want 0", {busy0, done0, pass0, dut_in0}); end
    n_vec++; if ({merr0, esum0, vcnt0, fvv0, fvl0} !== 21'h0) begin n_err++; $display("FAIL midreset_stats: got %h want 0", {merr0, esum0, vcnt0, fvv0, fvl0}); end
    @(negedge clk); rst_n = 1'b1;
    mode = 2'd0;
    do_sweep(0, 0, dc, bc, d1, s1);
    n_vec++; if (dc !== 17) begin n_err++; $display("FAIL midreset_rerun_done: got %0d want 17", dc); end
    n_vec++; if ({merr0, esum0, vcnt0, fvl0, pass0} !== 18'h1) begin n_err++; $display("FAIL midreset_rerun_stats: got max=%0d sum=%0d viol=%0d fvld=%b pass=%b", merr0, esum0, vcnt0, fvl0, pass0); end
  endtask

  task automatic test_back_to_back();
    int dc, bc; logic d1; logic [7:0] s1;
    mode = 2'd0;
    do_sweep(0, 0, dc, bc, d1, s1);
    n_vec++; if (d1 !== 1'b0) begin n_err++; $display("FAIL b2b_done_cleared: got %b want 0", d1); end
    n_vec++; if (s1 !== 8'd0) begin n_err++; $display("FAIL b2b_sum_cleared: got %0d want 0", s1); end
    n_vec++; if (dc !== 17) begin n_err++; $display("FAIL b2b_done_cycle: got %0d want 17", dc); end
    n_vec++; if ({merr0, esum0, vcnt0, fvl0, pass0} !== 18'h1) begin n_err++; $display("FAIL b2b_stats: got max=%0d sum=%0d viol=%0d fvld=%b pass=%b", merr0, esum0, vcnt0, fvl0, pass0); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_exact();
    test_stuck_high(0);
    test_stuck_low();
    test_latency();
    test_reset_mid_sweep();
    test_stuck_high(5);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/approx_adder_sweep_checker.md
Name: approx_adder_sweep_checker

Overview:
- Exhaustive sweep driver and error checker for one synthesised approximate adder netlist (default 4-in/3-out, error threshold 5).
- Sits directly around the combinational approximate adder. Upstream, it drives every input vector onto the netlist. Downstream, it consumes the netlist outputs, compares them with the exact sum and accumulates error statistics.
- Used in FPGA/sim harnesses to confirm a generated netlist meets its error threshold.

Parameters:
- OPW, 2, width of each adder operand; DUT input width is 2*OPW.
- ET, 5, error threshold; a vector violates when its absolute error is greater than ET.
- LAT, 0, cycles between dut_in changing and dut_out being sampled (0 = purely combinational DUT, max 3).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse that begins a sweep; ignored while busy.
- dut_in  out  2*OPW  vector driven to the DUT. Bits [OPW-1:0] are operand a, bits [2*OPW-1:OPW] are operand b; bit 0 is the LSB of a.
- dut_out  in  OPW+1  DUT sum output; bit 0 is the LSB.
- busy  out  1  high while sweeping or draining.
- done  out  1  high from sweep completion until the next start.
- pass  out  1  valid when done; 1 if viol_cnt == 0.
- max_err  out  OPW+1  largest absolute error seen.
- err_sum  out  3*OPW+2  sum of absolute errors over all vectors.
- viol_cnt  out  2*OPW+1  number of vectors with error greater than ET.
- first_viol_vec  out  2*OPW  first violating vector in sweep order.
- first_viol_vld  out  1  first_viol_vec holds a valid value.

Behaviour:
- Reset (async assert, sync deassert handled upstream): every output is 0, FSM is IDLE, and the vector counter and delay line are cleared.
- FSM states are IDLE, SWEEP, DRAIN and DONE.
- IDLE/DONE + start: all statistics clear to 0, first_viol_vld=0, done=0, vec=0; next state SWEEP, and busy rises the cycle after start.
- SWEEP: dut_in=vec (registered). vec increments every cycle from 0 to 2^(2*OPW)-1, so all vectors are driven in cycles 1..16 after start. After the last vector the state goes to DRAIN, or to DONE when LAT=0.
- DRAIN: waits LAT cycles; dut_in holds the last vector.
- Sampling: each driven vector passes through a delay line of depth LAT with a valid bit. The checker samples dut_out in the cycle where the delayed valid is high.
  - With LAT=0, sampling happens in the same cycle dut_in presents the vector.
- Per sample: exact = a + b (OPW+1 bits, no truncation); err = |dut_out - exact|, computed unsigned without wrap. Then:
  - err_sum += err;
  - max_err = max(max_err, err);
  - if err > ET: viol_cnt++, and if first_viol_vld=0, capture the vector and set first_viol_vld.
- Statistics update registered; values are final by the cycle done rises.
- DONE: entered the cycle after the last sample; busy=0, done=1, and pass = (viol_cnt == 0). Statistics hold until the next start or reset.
- A start pulse while busy is ignored; it has no effect on counters or state.
- Reset mid-sweep: immediate return to IDLE with everything cleared; a sweep never partially resumes.
- Vector-counter wrap: no wrap occurs; the terminal vector exits SWEEP.
- Counter widths are sized so no overflow is possible at defaults: err_sum max 16*7=112 < 256; viol_cnt max 16 < 32.

Test Plan:
- Exact model (dut_out = a+b), LAT=0, start at cycle 0 -> busy in cycles 1..16, done=1 at cycle 17, max_err=0, err_sum=0, viol_cnt=0, pass=1, first_viol_vld=0.
- dut_out stuck at 7 -> max_err=7, err_sum=64, viol_cnt=3, first_viol_vec=0, first_viol_vld=1, pass=0.
- dut_out stuck at 0 -> max_err=6, err_sum=48, viol_cnt=1, first_viol_vec=4'b1111, pass=0.
- LAT=2 with the exact model registered by 2 cycles -> identical results to the first test, with done rising at cycle 19.
- rst_n low at cycle 8 of a sweep -> all outputs 0 asynchronously. A later start then runs a full clean sweep with correct totals.
- start pulsed at cycle 5 during a sweep -> ignored; the results equal those of an uninterrupted sweep. A second start issued in DONE clears the statistics and reruns.
